// File: rtl/avalon_pulse_pio.sv
// Avalon-MM output PIO with per-channel level/pulse modes and SET/CLEAR aliases.
// Optional pulse-done interrupt (IRQ_PEND/IRQ_MASK, irq) enabled by defining PULSE_PIO_IRQ_EN.
module avalon_pulse_pio #(
   parameter int               WIDTH       = 8,
   parameter int               CNT_W       = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [2:0] A_DATA = 3'd0;
   localparam logic [2:0] A_MODE = 3'd1;
   localparam logic [2:0] A_SET  = 3'd2;
   localparam logic [2:0] A_CLR  = 3'd3;
   localparam logic [2:0] A_STAT = 3'd4;
   localparam logic [2:0] A_LEN  = 3'd5;
   localparam logic [2:0] A_PEND = 3'd6;
   localparam logic [2:0] A_MASK = 3'd7;

   // A zero pulse length would never expire, so it is stored as one.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] mode_q, mode_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] out_d, touch, wval, done, status;
   logic             unused_wd;

   assign wr        = chipselect && !write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;

   // DATA touches every channel; SET/CLEAR touch only the channels with a 1 in writedata.
   always_comb begin
      touch = '0;
      wval  = '0;
      if (wr) begin
         case (address)
            A_DATA:  begin touch = '1; wval = wd; end
            A_SET:   begin touch = wd; wval = wd; end
            A_CLR:   begin touch = wd; wval = '0; end
            default: ;
         endcase
      end
   end

   always_comb begin
      mode_d = (wr && address == A_MODE) ? wd : mode_q;
      len_d  = (wr && address == A_LEN) ? clamp_len(writedata[CNT_W-1:0]) : len_q;
      for (int i = 0; i < WIDTH; i++) begin
         out_d[i]  = out_port[i];
         cnt_d[i]  = cnt_q[i];
         done[i]   = 1'b0;
         status[i] = (cnt_q[i] != '0);
         // A CPU write beats expiry in the same cycle; leaving pulse mode drops the counter but keeps the bit.
         if (touch[i]) begin
            out_d[i] = wval[i];
            cnt_d[i] = (wval[i] && mode_q[i]) ? len_q : '0;
         end else if (mode_q[i] && !mode_d[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_W'(1)) begin
            out_d[i] = 1'b0;
            cnt_d[i] = '0;
            done[i]  = 1'b1;
         end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_port <= RESET_VALUE;
         mode_q   <= '0;
         len_q    <= CNT_W'(1);
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         out_port <= out_d;
         mode_q   <= mode_d;
         len_q    <= len_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

`ifdef PULSE_PIO_IRQ_EN
   logic [WIDTH-1:0] pend_q, pend_d, mask_q, mask_d;

   // A new pulse-done overrides a simultaneous W1C of the same bit.
   always_comb begin
      pend_d = pend_q;
      if (wr && address == A_PEND) pend_d = pend_d & ~wd;
      pend_d = pend_d | done;
      mask_d = (wr && address == A_MASK) ? wd : mask_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend_q <= '0;
         mask_q <= '0;
         irq    <= 1'b0;
      end else begin
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq    <= |(pend_d & mask_d);
      end
   end
`else
   logic unused_done;
   assign unused_done = ^done;
   assign irq         = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:  readdata = 32'(out_port);
         A_MODE:  readdata = 32'(mode_q);
         A_STAT:  readdata = 32'(status);
         A_LEN:   readdata = 32'(len_q);
`ifdef PULSE_PIO_IRQ_EN
         A_PEND:  readdata = 32'(pend_q);
         A_MASK:  readdata = 32'(mask_q);
`endif
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_avalon_pulse_pio.sv
// Bench for avalon_pulse_pio: directed steps, then random traffic against a deadline-based model.
module tb_avalon_pulse_pio;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_port;
   logic        irq;

   always #5 clk = ~clk;

   avalon_pulse_pio #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'hA5)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port), .irq(irq)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: each active pulse is described by the absolute edge number at which it falls.
   int         cyc;
   logic [7:0] m_out, m_mode, m_act, m_pend, m_mask;
   int         m_len;
   int         m_end [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_out = 8'hA5; m_mode = '0; m_act = '0; m_pend = '0; m_mask = '0; m_len = 1;
      for (int i = 0; i < 8; i++) m_end[i] = 0;
   endfunction

   function automatic void model_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
      logic [7:0] touch, val, done;
      cyc++;
      touch = '0; val = '0; done = '0;
      if (w && a == 3'd0) begin touch = 8'hFF; val = d[7:0]; end
      if (w && a == 3'd2) begin touch = d[7:0]; val = d[7:0]; end
      if (w && a == 3'd3) begin touch = d[7:0]; val = 8'h00; end
      for (int i = 0; i < 8; i++) begin
         if (m_act[i] && cyc == m_end[i] && !touch[i] && !(w && a == 3'd1 && m_mode[i] && !d[i])) begin
            m_out[i] = 1'b0; m_act[i] = 1'b0; done[i] = 1'b1;
         end
         if (touch[i]) begin
            m_out[i] = val[i];
            m_act[i] = val[i] && m_mode[i];
            if (m_act[i]) m_end[i] = cyc + m_len;
         end
      end
      if (w && a == 3'd1) begin
         m_act  = m_act & d[7:0];
         m_mode = d[7:0];
      end
      if (w && a == 3'd5) m_len = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
`ifdef PULSE_PIO_IRQ_EN
      if (w && a == 3'd6) m_pend = m_pend & ~d[7:0];
      if (w && a == 3'd7) m_mask = d[7:0];
      m_pend = m_pend | done;
`endif
   endfunction

   function automatic logic [31:0] model_read(input logic [2:0] a);
      case (a)
         3'd0: return {24'd0, m_out};
         3'd1: return {24'd0, m_mode};
         3'd4: return {24'd0, m_act};
         3'd5: return 32'(m_len);
`ifdef PULSE_PIO_IRQ_EN
         3'd6: return {24'd0, m_pend};
         3'd7: return {24'd0, m_mask};
`endif
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic model_irq();
`ifdef PULSE_PIO_IRQ_EN
      return |(m_pend & m_mask);
`else
      return 1'b0;
`endif
   endfunction

   task automatic cycle(input logic w, input logic [2:0] a, input logic [31:0] d);
      chipselect = w; write_n = !w; address = a; writedata = d;
      @(posedge clk);
      model_edge(w, a, d);
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
      chk("out_port", {24'd0, out_port}, {24'd0, m_out});
      chk("irq", {31'd0, irq}, {31'd0, model_irq()});
   endtask

   task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      chk(tag, readdata, exp);
      chipselect = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   int hi;

   initial begin
      reset = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      cyc = 0;
      model_reset();
      @(negedge clk);
      do_reset();
      chk("reset_out", {24'd0, out_port}, 32'h0000_00A5);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rd("reset_status", 3'd4, 32'd0);
      rd("reset_len", 3'd5, 32'd1);
      rd("reset_mode", 3'd1, 32'd0);

      cycle(1, 3'd0, 32'h0000_003C);
      chk("data_wr", {24'd0, out_port}, 32'h3C);
      cycle(1, 3'd2, 32'hFFFF_FF01 & 32'h0000_0001);
      chk("set_bit0", {24'd0, out_port}, 32'h3D);
      cycle(1, 3'd3, 32'h0000_0004);
      chk("clr_bit2", {24'd0, out_port}, 32'h39);
      rd("set_reads0", 3'd2, 32'd0);
      rd("clr_reads0", 3'd3, 32'd0);

      // 5-cycle pulse on bit0
      cycle(1, 3'd3, 32'h1);
      cycle(1, 3'd1, 32'h1);
      cycle(1, 3'd5, 32'h5);
      cycle(1, 3'd2, 32'h1);
      hi = int'(out_port[0]);
      rd("status_active", 3'd4, 32'h1);
      for (int k = 0; k < 9; k++) begin cycle(0, 3'd0, 0); hi += int'(out_port[0]); end
      chk("pulse5_len", 32'(hi), 32'd5);
      rd("status_done", 3'd4, 32'h0);
      chk("pulse5_others", {24'd0, out_port}, 32'h38);

      // zero length is stored as one
      cycle(1, 3'd5, 32'h0);
      rd("len0_read", 3'd5, 32'd1);
      cycle(1, 3'd2, 32'h1);
      hi = int'(out_port[0]);
      for (int k = 0; k < 4; k++) begin cycle(0, 3'd0, 0); hi += int'(out_port[0]); end
      chk("pulse1_len", 32'(hi), 32'd1);

      // retrigger on the 4th write slot of a 5-cycle pulse
      cycle(1, 3'd5, 32'h5);
      cycle(1, 3'd2, 32'h1);
      hi = int'(out_port[0]);
      cycle(0, 3'd0, 0); hi += int'(out_port[0]);
      cycle(0, 3'd0, 0); hi += int'(out_port[0]);
      cycle(1, 3'd2, 32'h1); hi += int'(out_port[0]);
      for (int k = 0; k < 10; k++) begin cycle(0, 3'd0, 0); hi += int'(out_port[0]); end
      chk("retrig_len", 32'(hi), 32'd8);

      // explicit clear mid-pulse
      cycle(1, 3'd2, 32'h1);
      cycle(0, 3'd0, 0);
      cycle(1, 3'd3, 32'h1);
      chk("clear_low", {31'd0, out_port[0]}, 32'd0);
      rd("clear_status", 3'd4, 32'd0);

      // write on the expiry cycle wins and retriggers
      cycle(1, 3'd5, 32'h3);
      cycle(1, 3'd2, 32'h1);
      hi = int'(out_port[0]);
      cycle(0, 3'd0, 0); hi += int'(out_port[0]);
      cycle(0, 3'd0, 0); hi += int'(out_port[0]);
      cycle(1, 3'd2, 32'h1); hi += int'(out_port[0]);
      for (int k = 0; k < 6; k++) begin cycle(0, 3'd0, 0); hi += int'(out_port[0]); end
      chk("collide_len", 32'(hi), 32'd6);

`ifdef PULSE_PIO_IRQ_EN
      cycle(1, 3'd6, 32'hFF);
      cycle(1, 3'd7, 32'h1);
      cycle(1, 3'd2, 32'h1);
      cycle(0, 3'd0, 0);
      cycle(0, 3'd0, 0);
      chk("irq_pre", {31'd0, irq}, 32'd0);
      cycle(0, 3'd0, 0);
      chk("irq_post", {31'd0, irq}, 32'd1);
      cycle(1, 3'd6, 32'h1);
      chk("irq_w1c", {31'd0, irq}, 32'd0);
`else
      cycle(1, 3'd6, 32'hFF);
      cycle(1, 3'd2, 32'h1);
      for (int k = 0; k < 4; k++) cycle(0, 3'd0, 0);
      chk("irq_off", {31'd0, irq}, 32'd0);
      rd("pend_reads0", 3'd6, 32'd0);
      rd("mask_reads0", 3'd7, 32'd0);
`endif

      // pulse->level mid-pulse keeps the bit, level->pulse does not start a count
      cycle(1, 3'd5, 32'h5);
      cycle(1, 3'd2, 32'h1);
      cycle(0, 3'd0, 0);
      cycle(1, 3'd1, 32'h0);
      rd("mode_lvl_status", 3'd4, 32'd0);
      cycle(1, 3'd1, 32'h1);
      for (int k = 0; k < 8; k++) cycle(0, 3'd0, 0);
      chk("mode_hold", {31'd0, out_port[0]}, 32'd1);
      rd("mode_hold_status", 3'd4, 32'd0);

      // reset mid-pulse
      cycle(1, 3'd2, 32'h1);
      do_reset();
      chk("reset_mid_out", {24'd0, out_port}, 32'hA5);
      rd("reset_mid_status", 3'd4, 32'd0);
      rd("reset_mid_mode", 3'd1, 32'd0);

      for (int k = 0; k < 600; k++) begin
         logic        w;
         logic [2:0]  a;
         logic [31:0] d;
         w = ($urandom_range(0, 2) != 0);
         a = 3'($urandom_range(0, 7));
         d = $urandom;
         if (a == 3'd5) d = 32'($urandom_range(0, 6));
         if (a == 3'd2 || a == 3'd3 || a == 3'd6) d = d & 32'($urandom_range(0, 255));
         cycle(w, a, d);
         a = 3'($urandom_range(0, 7));
         rd("rand_read", a, model_read(a));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/avalon_pulse_pio.md
# avalon_pulse_pio

Parametrised Avalon-MM output PIO: the multi-bit successor to the single-bit START/control output ports on the SoC's Avalon bus. It drives `WIDTH` independent output channels. Each channel runs in level mode (a plain register bit) or pulse mode (auto-clears after a programmable number of cycles). Software on the Nios side writes channels atomically through SET/CLEAR aliases, so fabric control strobes (game start, frame kick) need no read-modify-write and no timed clear.

## Interface
- `WIDTH`, 8: number of output channels, 1..32.
- `CNT_W`, 16: pulse-length counter width, 1..32.
- `RESET_VALUE`, 0: `WIDTH`-bit reset value of `out_port`.
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `address` in 3: word register index.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata` in 32: write data; bits above the register width are ignored.
- `readdata` out 32: combinational read data; zero-extended.
- `out_port` out `WIDTH`: channel outputs, driven directly from flops.
- `irq` out 1: pulse-done interrupt. Tied 0 unless `PULSE_PIO_IRQ_EN` is defined.

## Operation
- Register map, word addresses:
  - 0 DATA RW: full write of `out_port`.
  - 1 MODE RW: per bit, 0 = level, 1 = pulse.
  - 2 SET W: write-1-to-set.
  - 3 CLEAR W: write-1-to-clear.
  - 4 STATUS R: per-channel pulse-active bits.
  - 5 PULSE_LEN RW: `CNT_W` bits.
  - 6 IRQ_PEND (W1C), 7 IRQ_MASK (RW): present only with the macro.
  - Reads of SET and CLEAR return 0. Unused addresses read 0 and ignore writes.
- Reset values: `out_port` = `RESET_VALUE`, MODE = 0, PULSE_LEN = 1, all counters and STATUS = 0, IRQ_PEND = IRQ_MASK = 0, `irq` = 0.
- Level-mode channel: plain register bit. Set by DATA or SET, cleared by DATA or CLEAR.
- Pulse-mode channel, rising write: any write that drives the bit to 1 loads its counter with PULSE_LEN and sets STATUS. This applies whether the bit was 0 or 1 before, so writing 1 to an active pulse retriggers it.
- Pulse-mode counting: each cycle with the counter > 1, it decrements. When the counter equals 1 and no write touches the channel, the next edge clears the output bit, the counter and STATUS, and raises pulse-done for that channel.
- Result: the output is high for exactly PULSE_LEN cycles.
- PULSE_LEN write of 0 is stored as 1.
- Changing PULSE_LEN does not affect counters already running.
- Explicit clear of an active pulse (DATA bit 0 or CLEAR bit 1): output, counter and STATUS go to 0 on the next edge. No pulse-done is raised.
- MODE change pulse to level mid-pulse: the counter and STATUS clear, and the output holds its current value (1).
- MODE change level to pulse while the bit is already 1: no counter is loaded, and the bit stays 1 until a write.
- Simultaneous events:
  - A CPU write to a channel in the same cycle as its expiry wins. Set means retrigger; clear means no pulse-done.
  - Writes to different channels never interact.
- Reset asserted mid-pulse aborts everything to the reset values. No pulse-done is raised.

## Timing
- Write effects are visible on `out_port` one cycle after the write cycle (registered).
- A pulse written at edge N is high from after N through edge N+PULSE_LEN, then low.
- `readdata` is combinational from `address`, zero wait states. Reads have no side effects.
- `irq` is registered. It asserts the cycle after the expiry edge.

## Configuration
- `PULSE_PIO_IRQ_EN` defined:
  - Pulse-done sets the corresponding IRQ_PEND bit.
  - `irq` = |(IRQ_PEND & IRQ_MASK).
  - A W1C write to IRQ_PEND in the same cycle as a new pulse-done leaves the bit set (set wins).
- Not defined:
  - No IRQ_PEND or IRQ_MASK storage.
  - Addresses 6 and 7 read 0.
  - `irq` is constant 0.

## Test plan
- Reset with `RESET_VALUE`=8'hA5 -> `out_port`=8'hA5 and STATUS=0. Write DATA=8'h3C -> `out_port`=8'h3C one cycle later.
- SET 8'h01, then CLEAR 8'h04, starting from 8'h3C -> 8'h3D, then 8'h39. Other bits are untouched.
- MODE=8'h01, PULSE_LEN=5, SET 8'h01 -> bit0 high exactly 5 cycles, STATUS[0]=1 during the pulse and 0 after. PULSE_LEN=0 gives a 1-cycle pulse.
- Retrigger: SET bit0 again at cycle 3 of a 5-cycle pulse -> 8 high cycles in total. CLEAR bit0 at cycle 2 -> low next cycle, no pulse-done.
- Expiry-cycle collision: SET bit0 exactly on the expiry cycle -> stays high for a fresh PULSE_LEN.
- With `PULSE_PIO_IRQ_EN`: IRQ_MASK=1, 3-cycle pulse -> `irq` high the cycle after expiry; W1C IRQ_PEND=1 -> `irq` low. Without the macro -> `irq` stays 0 and address 6 reads 0.
